lfsr_stream_gen: RTL
====================

Name: lfsr_stream_gen

Overview:
- Multi-lane, parametrised LFSR stimulus source for the UVM testbench.
- Produces pseudo-random words on a valid/ready stream, in either bursts of a programmed length or continuously.
- Supports runtime seed reload and stop.
- Successor to the single-lane enable-stepped LFSR. It drives randomised addresses and write data into memory-controller request agents.

Parameters:
- LENGTH, 32, bits per lane. Supported values are 4, 8, 16, 32 and 64; any other value is an elaboration-time $error.
- NUM_CH, 2, number of independent lanes concatenated into out_data (≥1).
- KEY, '1 (LENGTH bits), base seed applied at reset.
- MAX_BURST, 256, largest programmable burst length. BW = $clog2(MAX_BURST+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- seed_load  in  1  load seed_data as the base seed (honoured in IDLE only)
- seed_data  in  LENGTH  new base seed
- start  in  1  begin a burst (honoured in IDLE only)
- burst_len  in  BW  beats per burst, sampled on start; 0 = continuous
- stop  in  1  end the current run early
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the word
- out_data  out  NUM_CH*LENGTH  lane i occupies bits [i*LENGTH +: LENGTH]
- out_last  out  1  final beat of the run
- busy  out  1  FSM is in RUN
- count  out  32  beats accepted since the last start; wraps modulo 2^32

Behaviour:
- Seed derivation:
  - base' = (base==0) ? '1 : base.
  - Lane i seed = base' ^ LENGTH'(i); if that result is 0, the lane seed is '1.
- Step (per lane):
  - lfsr <= {lfsr[LENGTH-2:0], fb}.
  - fb taps by LENGTH: 4 → b3^b2; 8 → b7^b5^b4^b3; 16 → b15^b13^b12^b10; 32 → b31^b21^b1^b0; 64 → b63^b62^b60^b59.
- Reset (asynchronous):
  - Lanes load seeds derived from KEY.
  - out_valid=0, out_last=0, busy=0, count=0, FSM=IDLE, stop_pend=0.
  - Reset asserted mid-burst aborts the burst immediately; no partial-handshake state survives.
- FSM IDLE:
  - out_valid=0.
  - seed_load reloads all lanes on the next edge.
  - start latches burst_len, clears count and moves to RUN; out_valid=1 from the next cycle.
  - If seed_load and start arrive together, the seed is loaded and the first word of the run is the new seed.
  - stop is ignored.
- FSM RUN:
  - out_valid=1 and out_data=current lane state. The first word of a run is the state held at start (no pre-step).
  - A handshake (out_valid & out_ready) steps all lanes and increments count.
  - Without a handshake, out_data and out_last hold stable.
  - seed_load and start are ignored.
- out_last (combinational) = stop_pend | (latched_len!=0 && count==latched_len-1).
- A handshake on a word with out_last=1 returns the FSM to IDLE; out_valid=0 the next cycle.
- stop in RUN:
  - With a handshake in the same cycle: that word was accepted as non-last and the FSM returns to IDLE.
  - Without a handshake: stop_pend is set, so the held word becomes last and the FSM returns to IDLE on its handshake.
  - stop_pend clears on entering IDLE.
- Lane state persists across runs: a new start continues the sequence unless a seed was loaded.
- Continuous mode (latched_len=0) runs until stop.
- Latency: start → first out_valid is 1 cycle; handshake → next word is 1 cycle; throughput is 1 beat/cycle with out_ready held high.

Decomposition:
- Package lfsr_stream_pkg:
  - typedef fsm_e {IDLE, RUN}.
  - Function tap_mask(LENGTH) returning the feedback tap vector.
  - Function lane_seed(base, i).
- Sub-module lfsr_lane:
  - Parameters LENGTH and SEED.
  - Ports clk, rst_n, load, load_val, step, state.
  - Instantiated NUM_CH times under generate.
- The FSM, burst counter and stop logic live in the top module.

Test Plan:
- LENGTH=4, NUM_CH=1, KEY=4'hF; start, burst_len=0, out_ready=1 → out_data F,E,C,8,1,2,4,9,3,6,D,A,5,B,7, then F again (period 15).
- Same configuration, burst_len=3 → beats F,E,C with out_last on C; busy=0 and count=3 afterwards. A second start with burst_len=2 → 8,1.
- Backpressure: out_ready=0 for 5 cycles mid-burst → out_valid=1 and out_data held stable; count unchanged until the handshake.
- LENGTH=4, NUM_CH=2, KEY=4'hF → first word 8'hEF, second 8'hCE. seed_load with seed_data=0 in IDLE, then start → first word 8'hEF.
- Continuous run, stop asserted while out_ready=0 → held word shows out_last=1, FSM goes IDLE after its handshake. stop asserted during a handshake → no further words.
- rst_n pulsed low mid-burst → out_valid, busy and out_last drop immediately; after release the first run restarts at F.

Source files
------------

// File: rtl/lfsr_stream_pkg.sv
// Shared types and helpers for the multi-lane LFSR stream generator:
// FSM encoding, feedback tap selection and per-lane seed derivation.
package lfsr_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  // All-ones mask of the low `length` bits, saturating at 64.
  function automatic logic [63:0] width_ones(input int length);
    return (length >= 64) ? '1 : ((64'd1 << length) - 64'd1);
  endfunction

  // Feedback taps, one bit set per tapped state bit.
  function automatic logic [63:0] tap_mask(input int length);
    case (length)
      4:       return 64'h0000_0000_0000_000C;
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return '0;
    endcase
  endfunction

  // A zero base maps to all-ones, each lane is offset by its index, and a
  // zero result is replaced by all-ones so no lane can lock up.
  function automatic logic [63:0] lane_seed(input logic [63:0] base, input int lane,
                                            input int length);
    logic [63:0] ones;
    logic [63:0] b;
    logic [63:0] s;
    ones = width_ones(length);
    b    = base & ones;
    if (b == '0) b = ones;
    s = (b ^ 64'(lane)) & ones;
    if (s == '0) s = ones;
    return s;
  endfunction

endpackage

// File: rtl/lfsr_lane.sv
// One Fibonacci LFSR lane: loadable, stepped on demand, shifts left with the
// feedback bit entering at bit 0.
module lfsr_lane
  import lfsr_stream_pkg::*;
#(
  parameter int              LENGTH = 32,
  parameter logic [LENGTH-1:0] SEED = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LENGTH-1:0] load_val,
  input  logic              step,
  output logic [LENGTH-1:0] state
);

  localparam logic [LENGTH-1:0] TAPS = LENGTH'(tap_mask(LENGTH));

  logic fb;
  assign fb = ^(state & TAPS);

  // NOTE: state uses <= so every lane samples the pre-edge value; the reset
  // value is the derived seed, never zero, since an all-zero LFSR never leaves zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= {state[LENGTH-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_stream_gen.sv
// Multi-lane LFSR word source on a valid/ready stream: bursts of a latched
// length or continuous runs, with seed reload in IDLE and early stop.
module lfsr_stream_gen
  import lfsr_stream_pkg::*;
#(
  parameter int                LENGTH    = 32,
  parameter int                NUM_CH    = 2,
  parameter logic [LENGTH-1:0] KEY       = '1,
  parameter int                MAX_BURST = 256,
  localparam int               BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     seed_load,
  input  logic [LENGTH-1:0]        seed_data,
  input  logic                     start,
  input  logic [BW-1:0]            burst_len,
  input  logic                     stop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*LENGTH-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic [31:0]              count
);

  if (!(LENGTH == 4 || LENGTH == 8 || LENGTH == 16 || LENGTH == 32 || LENGTH == 64))
  begin : g_bad_length
    $error("lfsr_stream_gen: unsupported LENGTH %0d", LENGTH);
  end
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("lfsr_stream_gen: NUM_CH must be at least 1, got %0d", NUM_CH);
  end

  fsm_e          state_q, state_d;
  logic [BW-1:0] len_q;
  logic          stop_pend;
  logic          idle, hs, load_seed, take_start, len_hit, leave_run;

  assign idle       = (state_q == IDLE);
  assign hs         = out_valid & out_ready;
  assign load_seed  = idle & seed_load;
  assign take_start = idle & start;
  assign len_hit    = (len_q != '0) && (count == 32'(len_q) - 32'd1);
  assign out_last   = out_valid & (stop_pend | len_hit);
  assign leave_run  = hs & (out_last | stop);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    lfsr_lane #(
      .LENGTH (LENGTH),
      .SEED   (LENGTH'(lane_seed(64'(KEY), i, LENGTH)))
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_seed),
      .load_val (LENGTH'(lane_seed(64'(seed_data), i, LENGTH))),
      .step     (hs),
      .state    (out_data[i*LENGTH +: LENGTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)     state_d = RUN;
      RUN:  if (leave_run) state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == RUN);
    busy      = (state_q == RUN);
  end

  // Burst length, beat counter and deferred stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      count     <= '0;
      stop_pend <= 1'b0;
    end else begin
      if (take_start) begin
        len_q <= burst_len;
        count <= '0;
      end else if (hs) begin
        count <= count + 32'd1;
      end
      stop_pend <= !idle && !leave_run && (stop_pend || stop);
    end
  end

endmodule
